ram_rd_streamer: RTL and testbench
==================================

Name: ram_rd_streamer

Overview:
- Read-side sequencer placed directly downstream of the 1-read/1-write synchronous RAM wrapper that supports backpressure.
- Accepts a command {base address, length}.
- Issues `length` consecutive read requests into the RAM's rd_req channel, wrapping modulo els_p.
- Converts the RAM's rd_resp channel into a valid/ready output stream with a last flag, used to feed the Reed-Solomon encoder datapath.

Parameters:
width_p, 64, RAM word width / output data width
els_p, 256, RAM depth in words; must match the RAM instance
addr_w_p, $clog2(els_p), RAM address width
len_w_p, addr_w_p+1, command length field width; maximum length is els_p

Ports:
clk  in  1  single clock; all logic rising-edge
rst_n  in  1  asynchronous active-low reset
cmd_val  in  1  command valid
cmd_base_addr  in  addr_w_p  first word address
cmd_len  in  len_w_p  words to read; 0 is a no-op
cmd_rdy  out  1  command ready
rd_req_val  out  1  RAM read request valid
rd_req_addr  out  addr_w_p  RAM read address
rd_req_rdy  in  1  RAM read request ready
rd_resp_val  in  1  RAM read response valid
rd_resp_data  in  width_p  RAM read response data
rd_resp_rdy  out  1  RAM read response ready
out_val  out  1  output stream valid
out_data  out  width_p  output word
out_last  out  1  marks final word of command
out_rdy  in  1  downstream ready
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; issue and receive counters = 0; address register = 0.
  - Outputs: cmd_rdy=1, rd_req_val=0, rd_req_addr=0, rd_resp_rdy=1, out_val=0, out_last=0, busy=0.
  - out_data is don't-care but must not be X-propagating into control.
- Integration drives the RAM's synchronous active-high rst from the same source, inverted. A reset asserted mid-command abandons the command; no partial output follows the reset.
- Handshakes: a transfer occurs on a cycle where val&rdy. Valid, once raised, is held with stable payload until accepted.
- IDLE:
  - cmd_rdy=1.
  - On cmd_val with cmd_len!=0: latch base and len, clear counters, go to ISSUE.
  - On cmd_len==0: accept the command, stay in IDLE, produce no output.
  - Any rd_resp_val in IDLE is stale: sink it (rd_resp_rdy=1) and do not forward it.
- ISSUE:
  - cmd_rdy=0.
  - rd_req_val=1 while issued<len.
  - rd_req_addr = (base + issued) mod els_p. Addition is done in addr_w_p bits, so wrap from els_p-1 to 0 is natural.
  - issued increments on rd_req_val&rd_req_rdy.
  - When the final request is accepted, go to DRAIN.
- DRAIN: rd_req_val=0; wait for the remaining responses.
- Response path (ISSUE and DRAIN), purely combinational pass-through; no added latency:
  - out_val = rd_resp_val.
  - out_data = rd_resp_data.
  - rd_resp_rdy = out_rdy.
- Backpressure relies on the RAM: its rd_req_rdy drops while its response is stalled, and it re-presents the stalled response.
- Receive counter:
  - received increments on out_val&out_rdy.
  - out_last = out_val & (received == len-1).
- Leaving DRAIN: when the word with out_last is accepted, go to IDLE. A new command may be accepted on the following cycle (1 dead cycle between commands).
- Latency: the first out_val is 1 cycle after the first accepted rd_req.
- Throughput: 1 word/cycle with out_rdy held high.
- Simultaneous events: a request accepted and a response accepted in the same cycle update both counters independently.
- Invariant: received <= issued <= len.
- Counters are len_w_p bits, so len=els_p (full-buffer read) is legal. Reading the full buffer from a nonzero base wraps exactly once.

Optional Feature:
- Macro: RD_STREAMER_STATS_EN.
- Defined: adds output ports
  - stat_stall_cycles (32 bits): increments every cycle with out_val&~out_rdy.
  - stat_cmds_done (32 bits): increments on each accepted out_last.
  - Both counters reset to 0 on rst_n, saturate at all-ones, and are not cleared between commands.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- base=0x10, len=4, out_rdy=1 → rd_req_addr 0x10..0x13 on consecutive cycles. Output data matches preloaded mem[0x10..0x13]; out_last only on the 4th word; busy falls the cycle after it.
- base=0xFE, len=4, els_p=256 → addresses 0xFE, 0xFF, 0x00, 0x01 in order; data matches those locations.
- len=8 with out_rdy toggling 1,0,0,1,... → exactly 8 words in order, no duplicates or drops. out_data stays stable while stalled. With the macro defined, stat_stall_cycles equals the number of stalled valid cycles.
- cmd_len=0 → cmd accepted in 1 cycle, no rd_req_val, no out_val, busy stays 0. A following len=1 command yields a single word with out_last=1.
- Assert rst_n low after 3 of 6 words → all outputs return to reset values immediately. A new len=2 command after release streams only its own 2 words.
- len=256, base=0x80 → 256 words, wrap at 0xFF→0x00, out_last on word 256. With the macro defined, stat_cmds_done increments by 1.

Source files
------------

// File: rtl/ram_rd_streamer.sv
// Read-side sequencer: turns {base,len} commands into RAM read requests and a last-tagged stream.
// Optional RD_STREAMER_STATS_EN adds saturating stall and completed-command counters.
module ram_rd_streamer #(
  parameter int width_p  = 64,
  parameter int els_p    = 256,
  parameter int addr_w_p = $clog2(els_p),
  parameter int len_w_p  = addr_w_p + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_val,
  input  logic [addr_w_p-1:0] cmd_base_addr,
  input  logic [len_w_p-1:0]  cmd_len,
  output logic                cmd_rdy,
  output logic                rd_req_val,
  output logic [addr_w_p-1:0] rd_req_addr,
  input  logic                rd_req_rdy,
  input  logic                rd_resp_val,
  input  logic [width_p-1:0]  rd_resp_data,
  output logic                rd_resp_rdy,
  output logic                out_val,
  output logic [width_p-1:0]  out_data,
  output logic                out_last,
  input  logic                out_rdy,
  output logic                busy
`ifdef RD_STREAMER_STATS_EN
  ,
  output logic [31:0]         stat_stall_cycles,
  output logic [31:0]         stat_cmds_done
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  localparam logic [len_w_p-1:0]  LOne = 1;
  localparam logic [addr_w_p-1:0] AOne = 1;

  state_e              state_q, state_d;
  logic [addr_w_p-1:0] addr_q, addr_d;
  logic [len_w_p-1:0]  len_q, len_d;
  logic [len_w_p-1:0]  issued_q, issued_d;
  logic [len_w_p-1:0]  rcvd_q, rcvd_d;
  logic                active;
  logic                req_fire;
  logic                out_fire;

  assign active   = (state_q != IDLE);
  assign req_fire = rd_req_val & rd_req_rdy;
  assign out_fire = out_val & out_rdy;

  always_comb begin
    cmd_rdy     = (state_q == IDLE);
    busy        = active;
    rd_req_val  = (state_q == ISSUE) && (issued_q < len_q);
    rd_req_addr = addr_q;
    // Outside a command, responses are stale: sink them, never forward.
    out_val     = active & rd_resp_val;
    out_data    = active ? rd_resp_data : '0;
    rd_resp_rdy = active ? out_rdy : 1'b1;
    out_last    = out_val && (rcvd_q == len_q - LOne);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    rcvd_d   = rcvd_q;
    if (out_fire) begin
      rcvd_d = rcvd_q + LOne;
    end
    unique case (state_q)
      IDLE: begin
        if (cmd_val && (cmd_len != '0)) begin
          addr_d   = cmd_base_addr;
          len_d    = cmd_len;
          issued_d = '0;
          rcvd_d   = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (req_fire) begin
          issued_d = issued_q + LOne;
          addr_d   = addr_q + AOne;
          if (issued_q == len_q - LOne) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_fire && out_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      rcvd_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      rcvd_q   <= rcvd_d;
    end
  end

`ifdef RD_STREAMER_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] done_q, done_d;

  always_comb begin
    stall_d = stall_q;
    done_d  = done_q;
    if (out_val && !out_rdy && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
    if (out_fire && out_last && (done_q != '1)) begin
      done_d = done_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      done_q  <= '0;
    end else begin
      stall_q <= stall_d;
      done_q  <= done_d;
    end
  end

  assign stat_stall_cycles = stall_q;
  assign stat_cmds_done    = done_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Directed + randomized bench for ram_rd_streamer with a backpressured RAM stub.
// Expected words come from a queue model built from base/len arithmetic over the memory image.
module tb_ram_rd_streamer;

  localparam int W  = 64;
  localparam int N  = 256;
  localparam int AW = 8;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_val;
  logic [AW-1:0] cmd_base_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_rdy;
  logic          rd_req_val;
  logic [AW-1:0] rd_req_addr;
  logic          rd_req_rdy;
  logic          rd_resp_val;
  logic [W-1:0]  rd_resp_data;
  logic          rd_resp_rdy;
  logic          out_val;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          out_rdy;
  logic          busy;
`ifdef RD_STREAMER_STATS_EN
  logic [31:0]   stat_stall_cycles;
  logic [31:0]   stat_cmds_done;
`endif

  logic          ram_en;
  logic [W-1:0]  mem [N];

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  int exp_addr[$];
  logic [W-1:0] exp_data[$];

  always #5 clk = ~clk;

  ram_rd_streamer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_val      (cmd_val),
    .cmd_base_addr(cmd_base_addr),
    .cmd_len      (cmd_len),
    .cmd_rdy      (cmd_rdy),
    .rd_req_val   (rd_req_val),
    .rd_req_addr  (rd_req_addr),
    .rd_req_rdy   (rd_req_rdy),
    .rd_resp_val  (rd_resp_val),
    .rd_resp_data (rd_resp_data),
    .rd_resp_rdy  (rd_resp_rdy),
    .out_val      (out_val),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_rdy      (out_rdy),
    .busy         (busy)
`ifdef RD_STREAMER_STATS_EN
    ,
    .stat_stall_cycles(stat_stall_cycles),
    .stat_cmds_done   (stat_cmds_done)
`endif
  );

  // RAM stub: one-cycle read latency; a stalled response is held and blocks new requests.
  assign rd_req_rdy = ram_en & (~rd_resp_val | rd_resp_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_resp_val  <= 1'b0;
      rd_resp_data <= '0;
    end else if (rd_req_val && rd_req_rdy) begin
      rd_resp_val  <= 1'b1;
      rd_resp_data <= mem[rd_req_addr];
    end else if (rd_resp_rdy) begin
      rd_resp_val  <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_rdy"}, cmd_rdy, 1);
    chk({tag, "_req_val"}, rd_req_val, 0);
    chk({tag, "_req_addr"}, rd_req_addr, 0);
    chk({tag, "_resp_rdy"}, rd_resp_rdy, 1);
    chk({tag, "_out_val"}, out_val, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Called at a negedge; returns at the negedge after the command is taken.
  task automatic send(input int base, input int len);
    cmd_val       = 1'b1;
    cmd_base_addr = AW'(base);
    cmd_len       = LW'(len);
    #1;
    chk("cmd_rdy", cmd_rdy, 1);
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back((base + i) % N);
      exp_data.push_back(mem[(base + i) % N]);
    end
    @(negedge clk);
    cmd_val = 1'b0;
  endtask

  // mode 0: out_rdy high; 1: pattern 1,0,0; 2: random out_rdy and RAM gaps.
  task automatic stream(input int mode, input int stop);
    int len = exp_data.size();
    int issued = 0;
    int got = 0;
    int cyc = 0;
    int first_req = -1;
    int first_val = -1;
    bit stalled = 0;
    logic [W-1:0] held = '0;
    while (got < stop && cyc < 8 * len + 40) begin
      out_rdy = (mode == 0) ? 1'b1 :
                (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(1));
      ram_en  = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
      #1;
      if (rd_req_val && rd_req_rdy) begin
        if (first_req < 0) first_req = cyc;
        if (issued < len) chk("req_addr", rd_req_addr, exp_addr[issued]);
        else chk("req_extra", issued, len - 1);
        issued++;
      end
      if (stalled) begin
        chk("val_hold", out_val, 1);
        chk("data_stable", out_data, held);
      end
      stalled = 0;
      if (out_val) begin
        if (first_val < 0) first_val = cyc;
        if (out_rdy) begin
          chk("out_data", out_data, exp_data[got]);
          chk("out_last", out_last, got == len - 1);
          if (got == len - 1) done_cnt++;
          got++;
        end else begin
          stall_cnt++;
          stalled = 1;
          held = out_data;
        end
      end
      cyc++;
      @(negedge clk);
    end
    chk("word_count", got, stop);
    if (mode == 0) chk("latency", first_val - first_req, 1);
    out_rdy = 1'b1;
    ram_en  = 1'b1;
    if (stop == len) begin
      #1;
      chk("busy_fall", busy, 0);
      for (int i = 0; i < 3; i++) begin
        chk("no_extra", out_val, 0);
        @(negedge clk);
        #1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    cmd_val       = 1'b0;
    cmd_base_addr = '0;
    cmd_len       = '0;
    out_rdy       = 1'b1;
    ram_en        = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(32'h10, 4);
    stream(0, 4);

    send(32'hFE, 4);
    stream(0, 4);

    send(32'h33, 8);
    stream(1, 8);

    send(32'h55, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("len0_busy", busy, 0);
      chk("len0_req", rd_req_val, 0);
      chk("len0_out", out_val, 0);
      @(negedge clk);
    end
    send(32'h20, 1);
    stream(0, 1);

    send(32'h40, 6);
    stream(0, 3);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    stall_cnt = 0;
    done_cnt  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h90, 2);
    stream(0, 2);

    send(32'h80, 256);
    stream(2, 256);

    for (int k = 0; k < 4; k++) begin
      send(int'($urandom_range(255)), int'($urandom_range(40, 1)));
      stream(2, exp_data.size());
    end

`ifdef RD_STREAMER_STATS_EN
    chk("stat_stall", stat_stall_cycles, stall_cnt);
    chk("stat_done", stat_cmds_done, done_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
